// File: rtl/id_decode_stage.sv
// id_decode_stage: IF/ID pipeline register with instruction decode, load-use hazard detection and flush/stall handling.
module id_decode_stage #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [15:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_ready,
  input  logic            flush,
  input  logic            ex_stall,
  output logic            id_fire,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [3:0]      opcode,
  output logic [2:0]      rd,
  output logic [2:0]      rs1,
  output logic [2:0]      rs2,
  output logic            immediate_signal,
  output logic [4:0]      I_immediate,
  output logic [8:0]      S_immediate,
  output logic            extOp,
  output logic            reg_write,
  output logic            is_load,
  output logic            is_store,
  output logic            illegal,
  output logic            load_use
);
  logic            valid_q, valid_d;
  logic [15:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ex_is_load_q, ex_is_load_d;
  logic [2:0]      ex_rd_q, ex_rd_d;
  logic            r_type, uses_rs1, uses_rs2, uses_rd, capture;
  assign id_valid         = valid_q;
  assign id_pc            = pc_q;
  assign opcode           = instr_q[15:12];
  assign rd               = instr_q[11:9];
  assign rs1              = instr_q[8:6];
  assign rs2              = instr_q[5:3];
  assign I_immediate      = instr_q[4:0];
  assign S_immediate      = instr_q[8:0];
  assign r_type           = opcode <= 4'h2;
  assign immediate_signal = opcode == 4'h9;
  assign extOp            = (opcode == 4'h3) | (opcode >= 4'h5 && opcode <= 4'h9);
  assign illegal          = valid_q & (opcode >= 4'hA);
  assign reg_write        = valid_q & (r_type | opcode == 4'h3 | opcode == 4'h4 | opcode == 4'h5);
  assign is_load          = valid_q & (opcode == 4'h5);
  assign is_store         = valid_q & (opcode == 4'h6 | opcode == 4'h9);
  // SW/BEQ/BNE/SV read the rd field as a source register
  assign uses_rs1         = opcode <= 4'h8;
  assign uses_rs2         = r_type;
  assign uses_rd          = opcode >= 4'h6 && opcode <= 4'h9;
  assign load_use         = valid_q & ex_is_load_q & (|ex_rd_q) &
                            ((uses_rs1 & rs1 == ex_rd_q) | (uses_rs2 & rs2 == ex_rd_q) | (uses_rd & rd == ex_rd_q));
  assign id_fire          = valid_q & ~load_use & ~ex_stall & ~flush;
  assign if_ready         = ~valid_q | id_fire;
  assign capture          = ~flush & if_ready & if_valid;
  always_comb begin
    valid_d      = flush ? 1'b0 : (if_ready ? if_valid : valid_q);
    instr_d      = capture ? if_instr : instr_q;
    pc_d         = capture ? if_pc : pc_q;
    ex_is_load_d = flush ? 1'b0 : (id_fire ? is_load : (ex_stall ? ex_is_load_q : 1'b0));
    ex_rd_d      = flush ? 3'd0 : (id_fire ? rd : (ex_stall ? ex_rd_q : 3'd0));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      instr_q      <= 16'h0000;
      pc_q         <= '0;
      ex_is_load_q <= 1'b0;
      ex_rd_q      <= 3'd0;
    end else begin
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      ex_is_load_q <= ex_is_load_d;
      ex_rd_q      <= ex_rd_d;
    end
  end
endmodule
